pwm: RTL and testbench

PWM -- requirements
Module: pwm

---
 rtl/pwm.sv | 45 ++++
 tb/tb_pwm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm.sv
// pwm: duty-adjustable PWM generator with synchronized pushbutton step inputs
//   params: PERIOD (clk cycles per PWM period), DUTY_INIT (high cycles after reset)
//   ports : clk, rst (sync, active-high), increase_duty / decrease_duty (async levels),
//           PWM_OUT (registered waveform, high for the first duty_act cycles of each period)
module pwm #(
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
);
  localparam int CW = $clog2(PERIOD);
  localparam int DW = $clog2(PERIOD + 1);
  logic [2:0]    inc_s, dec_s;
  logic          inc_p, dec_p, wrap;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty, duty_act, duty_nxt;
  // bit0 = s1, bit1 = s2 (synchronized level), bit2 = s3 (history for edge detect)
  assign inc_p = inc_s[1] & ~inc_s[2];
  assign dec_p = dec_s[1] & ~dec_s[2];
  assign wrap  = cnt == CW'(PERIOD - 1);
  always_comb
    duty_nxt = (inc_p & ~dec_p & (duty != DW'(PERIOD))) ? duty + 1'b1 :
               (dec_p & ~inc_p & (duty != '0))          ? duty - 1'b1 : duty;
  always_ff @(posedge clk)
    if (rst) begin
      inc_s    <= '0;
      dec_s    <= '0;
      cnt      <= '0;
      duty     <= DW'(DUTY_INIT);
      duty_act <= DW'(DUTY_INIT);
      PWM_OUT  <= 1'b0;
    end else begin
      inc_s    <= {inc_s[1:0], increase_duty};
      dec_s    <= {dec_s[1:0], decrease_duty};
      cnt      <= wrap ? '0 : cnt + 1'b1;
      duty     <= duty_nxt;
      // duty only takes effect at a period boundary so no period is cut short
      duty_act <= wrap ? duty : duty_act;
      PWM_OUT  <= DW'(cnt) < duty_act;
    end
endmodule

// File: tb/tb_pwm.sv
// tb_pwm: scoreboard bench for pwm, checks per-period PWM_OUT patterns against a duty model
module tb_pwm;
  logic clk = 1'b0, rst = 1'b1, increase_duty = 1'b0, decrease_duty = 1'b0;
  logic PWM_OUT;
  int vectors = 0, miscompares = 0, model_duty = 5, phase = 0;
  int exp_q[$];

  pwm #(.PERIOD(10), .DUTY_INIT(5)) dut (
    .clk(clk), .rst(rst), .increase_duty(increase_duty),
    .decrease_duty(decrease_duty), .PWM_OUT(PWM_OUT)
  );

  always #5 clk = ~clk;

  // cycle position within the period, counted from reset release
  always @(posedge clk) phase <= rst ? 0 : (phase == 9 ? 0 : phase + 1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_model(input logic inc, input logic dec);
    if (inc && !dec && model_duty < 10) model_duty++;
    else if (dec && !inc && model_duty > 0) model_duty--;
  endtask

  task automatic press(input logic inc, input logic dec, input int hold);
    increase_duty = inc;
    decrease_duty = dec;
    repeat (hold) @(negedge clk);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (10) @(negedge clk);
    step_model(inc, dec);
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (phase != 1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    ok = (phase == 1);
  endtask

  // samples one full period starting at the first output cycle and compares against the popped duty
  task automatic measure_period(input string name);
    bit ok;
    int d;
    logic [9:0] got, want;
    d = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    wait_start(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: period start not found, phase %0d want 1", name, phase);
      return;
    end
    for (int i = 0; i < 10; i++) begin
      got[i]  = PWM_OUT;
      want[i] = (i < d);
      @(negedge clk);
    end
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: PWM_OUT pattern got %b want %b (duty %0d)", name, got, want, d);
    end
  endtask

  task automatic expect_periods(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_duty);
      measure_period(name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      increase_duty = (i == 1);
      @(negedge clk);
      vectors++;
      if (PWM_OUT !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out: PWM_OUT got %b want 0", PWM_OUT);
      end
    end
    increase_duty = 1'b0;
    rst = 1'b0;
    model_duty = 5;
  endtask

  task automatic test_idle;
    expect_periods("idle_5of10", 5);
  endtask

  task automatic test_inc_dec;
    repeat (3) press(1'b1, 1'b0, 10);
    expect_periods("inc_to_8", 2);
    repeat (3) press(1'b0, 1'b1, 10);
    expect_periods("dec_to_5", 1);
    repeat (3) press(1'b1, 1'b0, 10);
    expect_periods("inc_again_8", 1);
  endtask

  task automatic test_mid_reset;
    bit ok;
    wait_start(ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (PWM_OUT !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_out: PWM_OUT got %b want 0", PWM_OUT);
    end
    rst = 1'b0;
    model_duty = 5;
    expect_periods("after_mid_reset", 2);
  endtask

  task automatic test_saturate;
    repeat (6) press(1'b1, 1'b0, 10);
    expect_periods("sat_high", 2);
    repeat (11) press(1'b0, 1'b1, 10);
    expect_periods("sat_low", 2);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_duty = 5;
  endtask

  task automatic test_hold;
    press(1'b1, 1'b0, 200);
    expect_periods("hold_one_step", 2);
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b1, 10);
    expect_periods("both_no_change", 1);
  endtask

  task automatic test_mid_period_change;
    bit ok;
    wait_start(ok);
    increase_duty = 1'b1;
    exp_q.push_back(model_duty);
    measure_period("change_old_period");
    step_model(1'b1, 1'b0);
    exp_q.push_back(model_duty);
    measure_period("change_new_period");
    increase_duty = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_held_press;
    rst = 1'b1;
    increase_duty = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_duty = 5;
    expect_periods("held_release_first", 1);
    step_model(1'b1, 1'b0);
    expect_periods("held_release_step", 2);
    increase_duty = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_idle;
    test_inc_dec;
    test_mid_reset;
    test_saturate;
    apply_reset;
    test_hold;
    test_simultaneous;
    test_mid_period_change;
    test_reset_held_press;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
